// File: rtl/sh_mem_banked_pkg.sv
// Shared encodings for the banked shared memory and its per-bank arbiter.
package sh_mem_banked_pkg;

  // Per-core request encoding on enable[2c+1:2c]; 11 behaves as a write.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

  // Arbitration policy codes.
  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Address-to-bank mapping codes.
  localparam int unsigned MAP_BLOCK      = 0;
  localparam int unsigned MAP_INTERLEAVE = 1;

  // Width of an index selecting one of n items, never below one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sh_mem_banked_rr_arbiter.sv
// Single-bank arbiter: rotating priority after ptr, or fixed lowest-index priority.
module rr_arbiter
  import sh_mem_banked_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned MODE = ARB_RR
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;
  logic             found;
  logic             unused_ptr;

  // ptr is ignored under fixed priority.
  assign unused_ptr = ^ptr;

  // First requester in search order wins; N is a power of two so the add wraps.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = |req;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (MODE == ARB_FIXED) cand = IDX_W'(i);
      else                   cand = ptr + IDX_W'(i + 1);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/sh_mem_banked.sv
// Multi-bank shared memory: per-bank arbitration, single-port bank RAMs, registered read return.
module sh_mem_banked
  import sh_mem_banked_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BANK_DEPTH = 256,
  parameter int unsigned INTERLEAVE = MAP_BLOCK,
  parameter int unsigned ARB_MODE   = ARB_RR
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [2*NUM_CORES-1:0]                                enable,
  input  logic [NUM_CORES*$clog2(NUM_BANKS*BANK_DEPTH)-1:0]     addr,
  input  logic [NUM_CORES*DATA_W-1:0]                           wr_data,
  output logic [NUM_CORES-1:0]                                  gnt,
  output logic [NUM_CORES-1:0]                                  rd_valid,
  output logic [NUM_CORES*DATA_W-1:0]                           rd_data
);

  localparam int unsigned ADDR_W = $clog2(NUM_BANKS * BANK_DEPTH);
  localparam int unsigned WORD_W = $clog2(BANK_DEPTH);
  localparam int unsigned BSEL_W = sel_width(NUM_BANKS);
  localparam int unsigned CID_W  = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] is_wr;
  logic [BSEL_W-1:0]    bsel       [NUM_CORES];
  logic [WORD_W-1:0]    widx       [NUM_CORES];
  logic [NUM_CORES-1:0] bank_gnt   [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
  logic [BSEL_W-1:0]    rd_src     [NUM_CORES];

  // Per-core request decode and address split; reset masks all requests.
  for (genvar gc = 0; gc < NUM_CORES; gc++) begin : g_core
    logic [1:0]        op_bits;
    logic [ADDR_W-1:0] a;
    assign op_bits   = enable[2*gc +: 2];
    assign a         = addr[gc*ADDR_W +: ADDR_W];
    assign req[gc]   = (op_bits != OP_IDLE) && !reset;
    assign is_wr[gc] = op_bits[1];
    if (NUM_BANKS == 1) begin : g_single
      assign bsel[gc] = '0;
      assign widx[gc] = a[WORD_W-1:0];
    end else if (INTERLEAVE == MAP_BLOCK) begin : g_block
      assign bsel[gc] = a[ADDR_W-1 -: BSEL_W];
      assign widx[gc] = a[WORD_W-1:0];
    end else begin : g_ilv
      assign bsel[gc] = a[BSEL_W-1:0];
      assign widx[gc] = a[ADDR_W-1 -: WORD_W];
    end
  end

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    logic [NUM_CORES-1:0] breq;
    logic [NUM_CORES-1:0] bgnt;
    logic [CID_W-1:0]     win;
    logic [CID_W-1:0]     ptr_q;
    logic                 bany;
    logic [DATA_W-1:0]    mem [BANK_DEPTH];
    logic [DATA_W-1:0]    rdata_q;

    // Candidates are requesting cores whose address selects this bank.
    always_comb begin
      breq = '0;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
        breq[c] = req[c] && (bsel[c] == BSEL_W'(gb));
      end
    end

    rr_arbiter #(.N(NUM_CORES), .MODE(ARB_MODE)) u_arb (
      .req (breq),
      .ptr (ptr_q),
      .gnt (bgnt),
      .idx (win),
      .any (bany)
    );

    // Rotating pointer remembers the last winner; reset gives core 0 first turn.
    always_ff @(posedge clk) begin
      if (reset)     ptr_q <= CID_W'(NUM_CORES - 1);
      else if (bany) ptr_q <= win;
    end

    // Single-port bank: the winner either writes or samples a word.
    always_ff @(posedge clk) begin
      if (bany) begin
        if (is_wr[win]) mem[widx[win]] <= wr_data[int'(win)*DATA_W +: DATA_W];
        else            rdata_q        <= mem[widx[win]];
      end
    end

    assign bank_gnt[gb]   = bgnt;
    assign bank_rdata[gb] = rdata_q;
  end

  // A core targets exactly one bank, so OR-ing bank grants yields its grant.
  always_comb begin
    gnt = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) gnt = gnt | bank_gnt[b];
  end

  // Read return tracking: one-cycle valid pulse plus the bank that holds the data.
  always_ff @(posedge clk) begin
    if (reset) rd_valid <= '0;
    else       rd_valid <= gnt & ~is_wr;
    for (int unsigned c = 0; c < NUM_CORES; c++) rd_src[c] <= bsel[c];
  end

  // Steer each bank's read register to its core lane; idle lanes read zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      if (rd_valid[c]) rd_data[c*DATA_W +: DATA_W] = bank_rdata[rd_src[c]];
    end
  end

endmodule

// File: tb/tb_sh_mem_banked.sv
// Directed self-checking bench: block-mapped round-robin DUT plus interleaved and fixed-priority variants.
module tb_sh_mem_banked;
  import sh_mem_banked_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  enable;
  logic [39:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  gnt, gnt_il, gnt_fp;
  logic [3:0]  rd_valid, rd_valid_il, rd_valid_fp;
  logic [31:0] rd_data, rd_data_il, rd_data_fp;

  int n_tests = 0;
  int n_fail  = 0;

  sh_mem_banked u_dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .wr_data(wr_data),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  sh_mem_banked #(.INTERLEAVE(1)) u_dut_il (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .wr_data(wr_data),
    .gnt(gnt_il), .rd_valid(rd_valid_il), .rd_data(rd_data_il)
  );

  sh_mem_banked #(.ARB_MODE(1)) u_dut_fp (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .wr_data(wr_data),
    .gnt(gnt_fp), .rd_valid(rd_valid_fp), .rd_data(rd_data_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int c, input logic [1:0] op, input logic [9:0] a, input logic [7:0] d);
    enable[2*c +: 2]  = op;
    addr[10*c +: 10]  = a;
    wr_data[8*c +: 8] = d;
  endtask

  task automatic clear_req();
    enable  = '0;
    addr    = '0;
    wr_data = '0;
  endtask

  task automatic do_reset_cycle();
    @(negedge clk);
    reset = 1'b1;
    clear_req();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) set_req(c, OP_RD, 10'(c * 256), 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt cyc%0d: got %b want 0000", i, gnt); end
      n_tests++;
      if (gnt_fp !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_fp cyc%0d: got %b want 0000", i, gnt_fp); end
    end
    @(negedge clk);
    reset = 1'b0;
    clear_req();
    #1;
    n_tests++;
    if (rd_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0000", rd_valid); end
    n_tests++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00000000", rd_data); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_req(0, OP_WR, 10'h010, 8'hA5); #1;
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wr_gnt: got %b want 0001", gnt); end
    @(negedge clk);
    set_req(0, OP_RD, 10'h010, 8'h00); #1;
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rd_gnt: got %b want 0001", gnt); end
    n_tests++;
    if (rd_valid !== 4'b0000) begin n_fail++; $display("FAIL wr_no_valid: got %b want 0000", rd_valid); end
    @(negedge clk);
    clear_req(); #1;
    n_tests++;
    if (rd_valid !== 4'b0001) begin n_fail++; $display("FAIL rd_valid_lat1: got %b want 0001", rd_valid); end
    n_tests++;
    if (rd_data !== 32'h000000A5) begin n_fail++; $display("FAIL rd_data_a5: got %h want 000000a5", rd_data); end
    @(negedge clk); #1;
    n_tests++;
    if (rd_valid !== 4'b0000) begin n_fail++; $display("FAIL rd_valid_pulse: got %b want 0000", rd_valid); end
  endtask

  task automatic test_parallel();
    @(negedge clk);
    for (int c = 0; c < 4; c++) set_req(c, OP_WR, 10'(c * 256), 8'(16 + c));
    #1;
    n_tests++;
    if (gnt !== 4'b1111) begin n_fail++; $display("FAIL par_wr_gnt: got %b want 1111", gnt); end
    @(negedge clk);
    for (int c = 0; c < 4; c++) set_req(c, OP_RD, 10'(c * 256), 8'h00);
    #1;
    n_tests++;
    if (gnt !== 4'b1111) begin n_fail++; $display("FAIL par_rd_gnt: got %b want 1111", gnt); end
    @(negedge clk);
    clear_req(); #1;
    n_tests++;
    if (rd_valid !== 4'b1111) begin n_fail++; $display("FAIL par_rd_valid: got %b want 1111", rd_valid); end
    n_tests++;
    if (rd_data !== 32'h13121110) begin n_fail++; $display("FAIL par_rd_data: got %h want 13121110", rd_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g [5];
    logic [3:0]  prev;
    logic [31:0] exp_d;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    prev = 4'b0000;
    do_reset_cycle();
    for (int c = 0; c < 4; c++) set_req(c, OP_RD, 10'h100, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_d = '0;
      for (int c = 0; c < 4; c++) if (prev[c]) exp_d[8*c +: 8] = 8'h11;
      n_tests++;
      if (gnt !== exp_g[i]) begin n_fail++; $display("FAIL rr_gnt cyc%0d: got %b want %b", i, gnt, exp_g[i]); end
      n_tests++;
      if (gnt_fp !== 4'b0001) begin n_fail++; $display("FAIL fp_gnt cyc%0d: got %b want 0001", i, gnt_fp); end
      n_tests++;
      if (rd_valid !== prev) begin n_fail++; $display("FAIL rr_rd_valid cyc%0d: got %b want %b", i, rd_valid, prev); end
      n_tests++;
      if (rd_data !== exp_d) begin n_fail++; $display("FAIL rr_rd_data cyc%0d: got %h want %h", i, rd_data, exp_d); end
      prev = exp_g[i];
    end
    @(negedge clk);
    clear_req();
  endtask

  task automatic test_interleave();
    logic [3:0] exp_il [3];
    logic [3:0] exp_bl [3];
    exp_il[0] = 4'b0101; exp_il[1] = 4'b0110; exp_il[2] = 4'b0101;
    exp_bl[0] = 4'b0001; exp_bl[1] = 4'b0010; exp_bl[2] = 4'b0100;
    do_reset_cycle();
    set_req(0, OP_RD, 10'h001, 8'h00);
    set_req(1, OP_RD, 10'h005, 8'h00);
    set_req(2, OP_RD, 10'h002, 8'h00);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_tests++;
      if (gnt_il !== exp_il[i]) begin n_fail++; $display("FAIL il_gnt cyc%0d: got %b want %b", i, gnt_il, exp_il[i]); end
      n_tests++;
      if (gnt !== exp_bl[i]) begin n_fail++; $display("FAIL blk_gnt cyc%0d: got %b want %b", i, gnt, exp_bl[i]); end
    end
    @(negedge clk);
    clear_req();
    set_req(0, OP_WR, 10'h005, 8'hC3); #1;
    n_tests++;
    if (gnt_il !== 4'b0001) begin n_fail++; $display("FAIL il_wr_gnt: got %b want 0001", gnt_il); end
    @(negedge clk);
    set_req(0, OP_WR, 10'h001, 8'h5A);
    @(negedge clk);
    set_req(0, OP_RD, 10'h005, 8'h00);
    @(negedge clk);
    clear_req(); #1;
    n_tests++;
    if (rd_valid_il !== 4'b0001) begin n_fail++; $display("FAIL il_rd_valid: got %b want 0001", rd_valid_il); end
    n_tests++;
    if (rd_data_il !== 32'h000000C3) begin n_fail++; $display("FAIL il_rd_data: got %h want 000000c3", rd_data_il); end
  endtask

  task automatic test_reset_mid();
    do_reset_cycle();
    set_req(0, OP_RD, 10'h010, 8'h00);
    set_req(1, OP_RD, 10'h010, 8'h00);
    #1;
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_first_gnt: got %b want 0001", gnt); end
    @(negedge clk);
    reset = 1'b1; #1;
    n_tests++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_gnt: got %b want 0000", gnt); end
    n_tests++;
    if (rd_valid !== 4'b0001) begin n_fail++; $display("FAIL mid_prior_valid: got %b want 0001", rd_valid); end
    @(negedge clk);
    reset = 1'b0; #1;
    n_tests++;
    if (rd_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_dropped_valid: got %b want 0000", rd_valid); end
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_reset_gnt: got %b want 0001", gnt); end
    @(negedge clk);
    clear_req(); #1;
    n_tests++;
    if (rd_valid !== 4'b0001) begin n_fail++; $display("FAIL mid_after_valid: got %b want 0001", rd_valid); end
    n_tests++;
    if (rd_data !== 32'h000000A5) begin n_fail++; $display("FAIL mid_after_data: got %h want 000000a5", rd_data); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_req();
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_parallel();
    test_round_robin();
    test_interleave();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
